// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the sync-window helper
// used by the snapshot front end.
package vga_timing_pkg;

   localparam int COUNT_W = 10;

   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;

   localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VIS + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VIS + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   // Half-open window [lo, hi) on a 10-bit counter.
   function automatic logic in_window(input logic [COUNT_W-1:0] cnt,
                                      input int lo, input int hi);
      return (cnt >= COUNT_W'(lo)) && (cnt < COUNT_W'(hi));
   endfunction

endpackage

// File: rtl/vga_sync_snapshot_if.sv
// Bundle between the matching-engine statistics, the timing generator and the
// trend display.
interface vga_sync_snapshot_if;
   import vga_timing_pkg::*;

   logic [7:0]         trade_price_i;
   logic               match_i;
   logic [7:0]         spread_i;
   logic [7:0]         trade_count_i;

   logic               pix_tick;
   logic [COUNT_W-1:0] h_cnt;
   logic [COUNT_W-1:0] v_cnt;
   logic               video_on;
   logic               hsync;
   logic               vsync;
   logic               frame_start;
   logic [7:0]         trade_price;
   logic               match_signal;
   logic [7:0]         spread;
   logic [7:0]         trade_count;

   // Engine / display side.
   modport master (
      output trade_price_i, match_i, spread_i, trade_count_i,
      input  pix_tick, h_cnt, v_cnt, video_on, hsync, vsync, frame_start,
             trade_price, match_signal, spread, trade_count
   );

   // Timing and snapshot block.
   modport slave (
      input  trade_price_i, match_i, spread_i, trade_count_i,
      output pix_tick, h_cnt, v_cnt, video_on, hsync, vsync, frame_start,
             trade_price, match_signal, spread, trade_count
   );

endinterface

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider plus run flag; pix_tick pulses once every PIX_DIV clocks
// once the block has left reset.
module vga_pix_tick #(
   parameter int PIX_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   output logic run,
   output logic pix_tick
);

   localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             run_q, run_d;

   // Divider holds at zero on the release edge so the first tick lands
   // exactly PIX_DIV clocks after reset is released.
   always_comb begin
      run_d = 1'b1;
      div_d = div_q;
      if (run_q)
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div_q <= '0;
         run_q <= 1'b0;
      end else begin
         div_q <= div_d;
         run_q <= run_d;
      end
   end

   assign run      = run_q;
   assign pix_tick = run_q && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_snapshot.sv
// VGA timing generator with a 1-clk price/match realignment stage and
// once-per-frame snapshots of spread and trade count taken at vblank entry.
module vga_sync_snapshot #(
   parameter int PIX_DIV = 2,
   parameter int H_VIS   = vga_timing_pkg::H_VIS,
   parameter int H_FP    = vga_timing_pkg::H_FP,
   parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
   parameter int H_BP    = vga_timing_pkg::H_BP,
   parameter int V_VIS   = vga_timing_pkg::V_VIS,
   parameter int V_FP    = vga_timing_pkg::V_FP,
   parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
   parameter int V_BP    = vga_timing_pkg::V_BP
) (
   input  logic               clk,
   input  logic               reset,
   vga_sync_snapshot_if.slave bus
);
   import vga_timing_pkg::*;

   localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VIS + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VIS + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam logic [COUNT_W-1:0] H_LAST    = COUNT_W'(H_TOTAL - 1);
   localparam logic [COUNT_W-1:0] V_LAST    = COUNT_W'(V_TOTAL - 1);
   localparam logic [COUNT_W-1:0] SNAP_LINE = COUNT_W'(V_VIS - 1);
   localparam logic [COUNT_W-1:0] H_VIS_C   = COUNT_W'(H_VIS);
   localparam logic [COUNT_W-1:0] V_VIS_C   = COUNT_W'(V_VIS);

   logic run, pix_tick;

   vga_pix_tick #(.PIX_DIV(PIX_DIV)) u_pix_tick (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .pix_tick (pix_tick)
   );

   logic [COUNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [COUNT_W-1:0] v_cnt_q, v_cnt_d;
   logic [7:0]         trade_price_q, trade_price_d;
   logic               match_q, match_d;
   logic [7:0]         spread_q, spread_d;
   logic [7:0]         trade_count_q, trade_count_d;
   logic               line_end, frame_end, snap_ld;

   always_comb begin
      line_end  = pix_tick && (h_cnt_q == H_LAST);
      frame_end = line_end && (v_cnt_q == V_LAST);
      snap_ld   = line_end && (v_cnt_q == SNAP_LINE);

      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pix_tick) begin
         if (line_end) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + COUNT_W'(1);
         end else begin
            h_cnt_d = h_cnt_q + COUNT_W'(1);
         end
      end

      // Price and match share one register stage so they stay paired.
      trade_price_d = bus.trade_price_i;
      match_d       = bus.match_i;

      // Stats load only on the edge entering the first blanked line, so the
      // display sees one coherent value for a whole frame.
      spread_d      = snap_ld ? bus.spread_i      : spread_q;
      trade_count_d = snap_ld ? bus.trade_count_i : trade_count_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         trade_price_q <= '0;
         match_q       <= 1'b0;
         spread_q      <= '0;
         trade_count_q <= '0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         trade_price_q <= trade_price_d;
         match_q       <= match_d;
         spread_q      <= spread_d;
         trade_count_q <= trade_count_d;
      end
   end

   always_comb begin
      bus.pix_tick     = pix_tick;
      bus.h_cnt        = h_cnt_q;
      bus.v_cnt        = v_cnt_q;
      bus.frame_start  = frame_end;
      bus.video_on     = run && (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
      bus.hsync        = !(run && in_window(h_cnt_q, HS_START, HS_END));
      bus.vsync        = !(run && in_window(v_cnt_q, VS_START, VS_END));
      bus.trade_price  = trade_price_q;
      bus.match_signal = match_q;
      bus.spread       = spread_q;
      bus.trade_count  = trade_count_q;
   end

endmodule
